mem_stage: RTL

Memory-access stage of the integer/floating-point pipeline, between the EXE/MEM register and the combinational write-back stage. It drives the data-memory request, waits for acknowledge under a two-state FSM with stall output, aligns/extends load data, builds store byte strobes, and owns the MEM/WB pipeline register whose outputs feed write-back directly.

---
 rtl/mem_pkg.sv | 15 +
 rtl/load_align.sv | 37 +++
 rtl/mem_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 encodings and FSM state type for the memory stage
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half/word lane and sign/zero-extends it
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = 8'h00;
        endcase
        // Halfword lane comes only from addr[1]; addr[0] is ignored.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = 32'h0;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    data_o = rdata_i;
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - data-memory access stage with ack-wait FSM and MEM/WB register
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_2_reg_src,
    input  logic [4:0]        ex_rd_addr,
    input  logic              ex_reg_write,
    input  logic              ex_f_reg_write,
    input  logic [31:0]       ex_f_alu_result,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              mem_stall,
    output logic [31:0]       rd_data,
    output logic [31:0]       DM_data_out,
    output logic [31:0]       f_alu_result,
    output logic              mem_2_reg_src,
    output logic              reg_write,
    output logic              f_reg_write,
    output logic [4:0]        rd_addr_out
);

    mem_state_t  state_q;
    logic [31:0] lat_alu_q, lat_sdata_q, lat_falu_q;
    logic [2:0]  lat_f3_q;
    logic [4:0]  lat_rd_q;
    logic        lat_we_q, lat_m2r_q, lat_rw_q, lat_frw_q;

    logic        in_wait, access, cur_we, cur_m2r, cur_rw, cur_frw;
    logic [31:0] cur_alu, cur_sdata, cur_falu, load_data;
    logic [2:0]  cur_f3;
    logic [4:0]  cur_rd;

    // In WAIT the request is replayed from the latched copy so upstream changes are ignored.
    assign in_wait   = (state_q == WAIT);
    assign access    = in_wait | (ex_valid & (ex_mem_read | ex_mem_write));
    assign cur_alu   = in_wait ? lat_alu_q   : ex_alu_result;
    assign cur_sdata = in_wait ? lat_sdata_q : ex_store_data;
    assign cur_falu  = in_wait ? lat_falu_q  : ex_f_alu_result;
    assign cur_f3    = in_wait ? lat_f3_q    : ex_funct3;
    assign cur_rd    = in_wait ? lat_rd_q    : ex_rd_addr;
    assign cur_we    = in_wait ? lat_we_q    : ex_mem_write;
    assign cur_m2r   = in_wait ? lat_m2r_q   : ex_mem_2_reg_src;
    assign cur_rw    = in_wait ? lat_rw_q    : (ex_valid & ex_reg_write);
    assign cur_frw   = in_wait ? lat_frw_q   : (ex_valid & ex_f_reg_write);

    assign dm_req    = access;
    assign dm_we     = access & cur_we;
    assign dm_addr   = {cur_alu[ADDR_W-1:2], 2'b00};
    assign mem_stall = access & ~dm_ack;

    always_comb begin
        dm_wstrb = 4'b0000;
        dm_wdata = 32'h0;
        if (access && cur_we) begin
            case (cur_f3[1:0])
                2'b00: begin
                    dm_wstrb = 4'b0001 << cur_alu[1:0];
                    dm_wdata = {4{cur_sdata[7:0]}};
                end
                2'b01: begin
                    dm_wstrb = cur_alu[1] ? 4'b1100 : 4'b0011;
                    dm_wdata = {2{cur_sdata[15:0]}};
                end
                2'b10: begin
                    dm_wstrb = 4'b1111;
                    dm_wdata = cur_sdata;
                end
                default: begin
                    dm_wstrb = 4'b0000;
                    dm_wdata = 32'h0;
                end
            endcase
        end
    end

    load_align u_load_align (
        .rdata_i   (dm_rdata),
        .addr_lo_i (cur_alu[1:0]),
        .funct3_i  (cur_f3),
        .data_o    (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lat_alu_q     <= 32'h0;
            lat_sdata_q   <= 32'h0;
            lat_falu_q    <= 32'h0;
            lat_f3_q      <= 3'b000;
            lat_rd_q      <= 5'd0;
            lat_we_q      <= 1'b0;
            lat_m2r_q     <= 1'b0;
            lat_rw_q      <= 1'b0;
            lat_frw_q     <= 1'b0;
            rd_data       <= 32'h0;
            DM_data_out   <= 32'h0;
            f_alu_result  <= 32'h0;
            mem_2_reg_src <= 1'b0;
            reg_write     <= 1'b0;
            f_reg_write   <= 1'b0;
            rd_addr_out   <= 5'd0;
        end else begin
            if (!in_wait) begin
                lat_alu_q   <= ex_alu_result;
                lat_sdata_q <= ex_store_data;
                lat_falu_q  <= ex_f_alu_result;
                lat_f3_q    <= ex_funct3;
                lat_rd_q    <= ex_rd_addr;
                lat_we_q    <= ex_mem_write;
                lat_m2r_q   <= ex_mem_2_reg_src;
                lat_rw_q    <= ex_valid & ex_reg_write;
                lat_frw_q   <= ex_valid & ex_f_reg_write;
            end
            state_q <= mem_stall ? WAIT : IDLE;

            if (mem_stall) begin
                reg_write   <= 1'b0;
                f_reg_write <= 1'b0;
            end else begin
                rd_data       <= cur_alu;
                f_alu_result  <= cur_falu;
                rd_addr_out   <= cur_rd;
                mem_2_reg_src <= cur_m2r;
                reg_write     <= cur_rw;
                f_reg_write   <= cur_frw;
                DM_data_out   <= (access && !cur_we) ? load_data : 32'h0;
            end
        end
    end

endmodule
